reg_file_8x8: RTL
=================

REG_FILE_8X8 -- requirements
Module: reg_file_8x8

Interface
REQ-001 SHALL have parameter: DATA_W, 8, width of each register and data port.
REQ-002 SHALL have parameter: ADDR_W, 3, address width; register count = 2**ADDR_W.
REQ-003 SHALL have port: CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: RESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: IN  input  DATA_W  write data.
REQ-006 SHALL have port: INADDRESS  input  ADDR_W  write address.
REQ-007 SHALL have port: WRITE  input  1  write enable, sampled on rising CLK.
REQ-008 SHALL have port: READ  input  1  read request, sampled on rising CLK.
REQ-009 SHALL have port: OUT1ADDRESS  input  ADDR_W  read port 1 address.
REQ-010 SHALL have port: OUT2ADDRESS  input  ADDR_W  read port 2 address.
REQ-011 SHALL have port: OUT1  output  DATA_W  registered read data 1; feeds operand mux IN1.
REQ-012 SHALL have port: OUT2  output  DATA_W  registered read data 2; feeds operand mux IN2.
REQ-013 SHALL have port: VALID  output  1  OUT1/OUT2 updated by the last edge's READ.

Function
REQ-014 SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-015 SHALL, on rising CLK with WRITE=1, store IN into register INADDRESS; WRITE=0 leaves all registers unchanged.
REQ-016 SHALL, on rising CLK with READ=1, load OUT1 <= reg[OUT1ADDRESS] and OUT2 <= reg[OUT2ADDRESS] as they held before that edge (one-cycle read latency).
REQ-017 SHALL hold OUT1/OUT2 unchanged on any edge with READ=0.
REQ-018 SHALL set VALID=1 for the cycle following each edge with READ=1, and VALID=0 after each edge with READ=0; back-to-back READ keeps VALID high.
REQ-019 SHALL permit WRITE and READ on the same edge; different addresses act independently.
REQ-020 SHALL, for same-edge READ and WRITE to one address, return the pre-write value unless bypass is compiled in (REQ-027).
REQ-021 SHALL permit OUT1ADDRESS == OUT2ADDRESS; both outputs receive the same value.
REQ-022 SHALL use all ADDR_W address bits with no aliasing; the top address (7 by default) is an ordinary register.
REQ-023 SHALL never modify data width: no truncation, extension or sign handling.

Reset
REQ-024 SHALL, while RESETN=0, immediately and independently of CLK force every register, OUT1, OUT2 and VALID to 0.
REQ-025 SHALL discard any WRITE or READ coinciding with an active reset edge; the first operation takes effect on the first rising CLK with RESETN=1.
REQ-026 SHALL, on reset asserted mid-sequence, lose all stored data; no partial state survives.

Configuration
REQ-027 SHALL, with macro REG_FILE_BYPASS_EN defined, forward IN to OUT1 (and/or OUT2) on a same-edge READ when WRITE=1 and INADDRESS equals that port's read address; the register is still written.
REQ-028 SHALL, without REG_FILE_BYPASS_EN, contain no bypass logic and behave per REQ-020.

Verification
REQ-029 SHALL cover: RESETN low mid-cycle after registers written -> OUT1=OUT2=0, VALID=0 at once; READ of all addresses -> 0x00.
REQ-030 SHALL cover: WRITE IN=0xA5 to addr 3, next edge READ OUT1ADDRESS=3, OUT2ADDRESS=7 -> cycle after: OUT1=0xA5, OUT2=0x00, VALID=1.
REQ-031 SHALL cover: write 0x11 to addr 2, then same-edge WRITE 0x22 to addr 2 with READ OUT1ADDRESS=2 -> OUT1=0x11 without macro, 0x22 with REG_FILE_BYPASS_EN; following READ -> 0x22 both builds.
REQ-032 SHALL cover: READ pulses on edges 1,2, idle on 3, with register changes in between -> VALID 1,1,0; OUT1/OUT2 frozen after edge 3.
REQ-033 SHALL cover: write 0xFF to addr 7 and 0x01 to addr 0, READ both ports addr 7 -> OUT1=OUT2=0xFF; addr 0 still 0x01 (no aliasing).
REQ-034 SHALL cover: WRITE=0 with IN=0x5A, INADDRESS=4 on three edges -> READ addr 4 returns prior value unchanged.

Source files
------------

// File: rtl/reg_file_8x8.sv
// 8x8 register file: one write port, two registered read ports; reads see pre-edge contents.
// Latency 1 cycle on reads; no backpressure (every edge accepts WRITE/READ). Optional REG_FILE_BYPASS_EN forwards same-edge write data.
// Asynchronous active-low RESETN clears storage, outputs and VALID immediately.
module reg_file_8x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic              READ,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              VALID
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] rd1_dat;
    logic [DATA_W-1:0] rd2_dat;

    always_comb begin
        rd1_dat = regs[OUT1ADDRESS];
        rd2_dat = regs[OUT2ADDRESS];
`ifdef REG_FILE_BYPASS_EN
        // Same-edge write to the addressed register wins over stored data.
        if (WRITE && (INADDRESS == OUT1ADDRESS)) rd1_dat = IN;
        if (WRITE && (INADDRESS == OUT2ADDRESS)) rd2_dat = IN;
`endif
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            regs  <= '{default: '0};
            OUT1  <= '0;
            OUT2  <= '0;
            VALID <= 1'b0;
        end else begin
            if (WRITE) regs[INADDRESS] <= IN;
            if (READ) begin
                OUT1 <= rd1_dat;
                OUT2 <= rd2_dat;
            end
            VALID <= READ;
        end
    end

endmodule
